// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back bundle layout, register-file widths
// and the write scheduler state encoding.
package cpu_pkg;

  localparam int WB_RESULT_W  = 38;
  localparam int WB_VALID_BIT = 37;
  localparam int WB_DEST_HI   = 36;
  localparam int WB_DEST_LO   = 32;
  localparam int WB_DATA_HI   = 31;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } schedState_t;

endpackage

// File: rtl/rf_write_sched_if.sv
// Bus between the write-back/LU producers (master) and the register-file
// write scheduler (slave).
//   wb_result            : write-back bundle {valid, dest, data}
//   lu_valid/dest/data   : long-latency unit result offer
//   lu_ready             : scheduler can buffer an LU result
//   delay                : freeze upstream, wb_result is held
//   rf_we/waddr/wdata    : registered register-file write port
//   busy                 : LU buffer non-empty
interface rf_write_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [cpu_pkg::WB_RESULT_W-1:0] wb_result;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_dest;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              delay;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;

  modport master (
    output wb_result, lu_valid, lu_dest, lu_data,
    input  lu_ready, delay, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  wb_result, lu_valid, lu_dest, lu_data,
    output lu_ready, delay, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering LU results ({dest,data}).
//   clk, reset (async active-low)
//   wrEn/wrData : push (ignored when full)
//   rdEn/rdData : pop (ignored when empty), rdData shows the head
//   count/full/empty : occupancy, all from registered state
module rf_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wrEn,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       rdEn,
  output logic [WIDTH-1:0]           rdData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             doWr, doRd;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doWr   = wrEn && !full;
  assign doRd   = rdEn && !empty;
  assign rdData = mem[rdPtr];

  // Storage needs no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= wrData;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + PTR_W'(1);
      if (doRd) rdPtr <= rdPtr + PTR_W'(1);
      case ({doWr, doRd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_write_sched.sv
// Register-file write port scheduler. The in-order write-back result wins
// by default; buffered LU results take bubbles, or steal the port for one
// cycle (raising delay) when the buffer is full or the head has been
// passed over MAX_WAIT times.
//   clk, reset (async active-low)
//   bus : rf_write_sched_if.slave (write-back, LU offer, RF write, status)
//
//   state | meaning
//   IDLE  | LU buffer empty, write-back owns the port
//   WAIT  | LU head pending, granted on a bubble or by a forced steal
module rf_write_sched #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic clk,
  input  logic reset,
  rf_write_sched_if.slave bus
);
  import cpu_pkg::*;

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  schedState_t        state;
  logic [WAIT_W-1:0]  waitCnt;
  logic               rfWe;
  logic [ADDR_W-1:0]  rfWaddr;
  logic [DATA_W-1:0]  rfWdata;

  logic               wbValid;
  logic [ADDR_W-1:0]  wbDest;
  logic [DATA_W-1:0]  wbData;
  logic [ADDR_W+DATA_W-1:0] headEntry;
  logic [ADDR_W-1:0]  headDest;
  logic [DATA_W-1:0]  headData;
  logic [CNT_W-1:0]   fifoCount;
  logic               fifoFull, fifoEmpty;
  logic               enq, forceSteal, grantLu, grantWb;

  assign wbValid  = bus.wb_result[WB_VALID_BIT];
  assign wbDest   = bus.wb_result[WB_DEST_HI:WB_DEST_LO];
  assign wbData   = bus.wb_result[WB_DATA_HI:0];
  assign headDest = headEntry[ADDR_W+DATA_W-1:DATA_W];
  assign headData = headEntry[DATA_W-1:0];

  // Acceptance looks only at the registered count: a full buffer refuses
  // even in a cycle where it also drains.
  assign enq = bus.lu_valid && !fifoFull;

  assign forceSteal = (state == WAIT) && wbValid &&
                      (fifoFull || (waitCnt == WAIT_LIMIT));
  assign grantLu    = (state == WAIT) && (!wbValid || forceSteal);
  assign grantWb    = wbValid && !grantLu;

  rf_wb_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (enq),
    .wrData ({bus.lu_dest, bus.lu_data}),
    .rdEn   (grantLu),
    .rdData (headEntry),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      rfWe    <= 1'b0;
      rfWaddr <= '0;
      rfWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (enq) state <= WAIT;
        end
        WAIT: begin
          if (grantLu) begin
            waitCnt <= '0;
            if ((fifoCount == CNT_W'(1)) && !enq) state <= IDLE;
          end else if (waitCnt != WAIT_LIMIT) begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // r0 is hard-wired: a grant to dest 0 is consumed without a write.
      if (grantLu) begin
        rfWe    <= (headDest != '0);
        rfWaddr <= headDest;
        rfWdata <= headData;
      end else if (grantWb) begin
        rfWe    <= (wbDest != '0);
        rfWaddr <= wbDest;
        rfWdata <= wbData;
      end else begin
        rfWe <= 1'b0;
      end
    end
  end

  assign bus.lu_ready = !fifoFull;
  assign bus.delay    = forceSteal;
  assign bus.busy     = !fifoEmpty;
  assign bus.rf_we    = rfWe;
  assign bus.rf_waddr = rfWaddr;
  assign bus.rf_wdata = rfWdata;
endmodule

// File: tb/tb_rf_write_sched.sv
module tb_rf_write_sched;
  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  typedef struct {
    logic        v;
    logic [4:0]  d;
    logic [31:0] x;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_write_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_write_sched #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int testsRun = 0;
  int testsFailed = 0;

  ent_t wbStim[$];
  ent_t luStim[$];
  ent_t wbCur, luCur;
  bit   randMode = 0;

  // Reference: LU buffer as a queue, pass-over count as an integer.
  ent_t        modelQ[$];
  int          modelWait;
  logic        expWe;
  logic [4:0]  expAddr;
  logic [31:0] expData;

  logic [4:0]  wrLog[$];
  logic [4:0]  expLog[$];
  int          delayCnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic v, input logic [4:0] d, input logic [31:0] x);
    ent_t e;
    e.v = v; e.d = d; e.x = x;
    return e;
  endfunction

  function automatic ent_t nextWb();
    if (wbStim.size() != 0) return wbStim.pop_front();
    if (randMode) return mk($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom);
    return mk(1'b0, 5'd0, 32'd0);
  endfunction

  function automatic ent_t nextLu();
    if (luStim.size() != 0) return luStim.pop_front();
    if (randMode) return mk($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom);
    return mk(1'b0, 5'd0, 32'd0);
  endfunction

  task automatic loadCur();
    wbCur = nextWb();
    luCur = nextLu();
  endtask

  task automatic runCycles(input int n);
    bit   full, pend, forceE, gLu, gWb, accepted;
    ent_t gEnt;
    for (int i = 0; i < n; i++) begin
      bus.wb_result = {wbCur.v, wbCur.d, wbCur.x};
      bus.lu_valid  = luCur.v;
      bus.lu_dest   = luCur.d;
      bus.lu_data   = luCur.x;
      @(negedge clk);
      pend   = (modelQ.size() != 0);
      full   = (modelQ.size() == DEPTH);
      forceE = wbCur.v && pend && (full || modelWait >= MAXW);
      chk("delay", bus.delay, forceE);
      chk("lu_ready", bus.lu_ready, !full);
      chk("busy", bus.busy, pend);
      if (bus.delay) delayCnt++;
      gLu = pend && (!wbCur.v || forceE);
      gWb = wbCur.v && !gLu;
      gEnt = gLu ? modelQ[0] : wbCur;
      accepted = luCur.v && !full;
      @(posedge clk);
      #1;
      if (gLu) begin
        void'(modelQ.pop_front());
        modelWait = 0;
      end else if (gWb && pend) begin
        modelWait = (modelWait + 1 > MAXW) ? MAXW : modelWait + 1;
      end
      if (accepted) modelQ.push_back(luCur);
      if (gLu || gWb) begin
        expWe   = (gEnt.d != 5'd0);
        expAddr = gEnt.d;
        expData = gEnt.x;
      end else begin
        expWe = 1'b0;
      end
      chk("rf_we", bus.rf_we, expWe);
      chk("rf_waddr", bus.rf_waddr, expAddr);
      chk("rf_wdata", bus.rf_wdata, expData);
      if (bus.rf_we) wrLog.push_back(bus.rf_waddr);
      if (!forceE) wbCur = nextWb();
      if (accepted || !luCur.v) luCur = nextLu();
    end
  endtask

  task automatic checkLog(input string tag);
    chk({tag, "_len"}, 64'(wrLog.size()), 64'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < wrLog.size(); i++)
      chk(tag, wrLog[i], expLog[i]);
  endtask

  task automatic startScenario();
    wrLog.delete();
    delayCnt = 0;
    loadCur();
  endtask

  task automatic doReset(input string tag);
    bus.wb_result = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_dest   = '0;
    bus.lu_data   = '0;
    reset = 1'b0;
    #1;
    chk({tag, "_rf_we"}, bus.rf_we, 1'b0);
    chk({tag, "_rf_waddr"}, bus.rf_waddr, 5'd0);
    chk({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_lu_ready"}, bus.lu_ready, 1'b1);
    chk({tag, "_delay"}, bus.delay, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    modelQ.delete();
    modelWait = 0;
    expWe = 1'b0;
    expAddr = '0;
    expData = '0;
    wbStim.delete();
    luStim.delete();
    wbCur = mk(1'b0, 5'd0, 32'd0);
    luCur = mk(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    #3;
    doReset("rst0");

    // Write-back only.
    wbStim.push_back(mk(1'b1, 5'd3, 32'h0000_1234));
    startScenario();
    runCycles(3);
    expLog = '{5'd3};
    checkLog("wb_only");

    // LU result into a bubble.
    luStim.push_back(mk(1'b1, 5'd7, 32'h0000_00AA));
    startScenario();
    runCycles(4);
    expLog = '{5'd7};
    checkLog("lu_bubble");
    chk("lu_bubble_delays", 64'(delayCnt), 64'd0);

    // Starvation: LU entry arrives, then continuous write-back.
    wbStim.push_back(mk(1'b0, 5'd0, 32'd0));
    for (int i = 1; i <= 6; i++) wbStim.push_back(mk(1'b1, 5'(i), 32'h100 + 32'(i)));
    luStim.push_back(mk(1'b1, 5'd9, 32'hDEAD_0009));
    startScenario();
    runCycles(12);
    expLog = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5, 5'd6};
    checkLog("starve");
    chk("starve_delays", 64'(delayCnt), 64'd1);

    // Full buffer: two back-to-back LU entries under continuous write-back.
    for (int i = 10; i <= 17; i++) wbStim.push_back(mk(1'b1, 5'(i), 32'h200 + 32'(i)));
    luStim.push_back(mk(1'b1, 5'd20, 32'hCAFE_0020));
    luStim.push_back(mk(1'b1, 5'd21, 32'hCAFE_0021));
    startScenario();
    runCycles(14);
    expLog = '{5'd10, 5'd11, 5'd20, 5'd12, 5'd13, 5'd14, 5'd15, 5'd21, 5'd16, 5'd17};
    checkLog("full");
    chk("full_delays", 64'(delayCnt), 64'd2);

    // Destination 0 on both sides.
    wbStim.push_back(mk(1'b1, 5'd0, 32'h0000_0055));
    luStim.push_back(mk(1'b1, 5'd0, 32'h0000_0066));
    startScenario();
    runCycles(4);
    expLog.delete();
    checkLog("dest0");
    chk("dest0_busy", bus.busy, 1'b0);

    // Reset with two LU entries buffered.
    for (int i = 1; i <= 8; i++) wbStim.push_back(mk(1'b1, 5'(i), 32'h300 + 32'(i)));
    luStim.push_back(mk(1'b1, 5'd11, 32'h0000_0B0B));
    luStim.push_back(mk(1'b1, 5'd12, 32'h0000_0C0C));
    startScenario();
    runCycles(2);
    chk("prerst_busy", bus.busy, 1'b1);
    chk("prerst_lu_ready", bus.lu_ready, 1'b0);
    doReset("rst_mid");
    startScenario();
    runCycles(5);
    expLog.delete();
    checkLog("post_rst");

    // Randomized traffic against the reference model.
    randMode = 1;
    startScenario();
    runCycles(2000);
    randMode = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
